// File: rtl/grid_pkg.sv
// -----------------------------------------------------------------------------
// grid_pkg
// Shared constants and types for the grid cursor controller.
//   - Grid geometry (columns, rows, cell size, pixels per square)
//   - Draw-phase timeout
//   - FSM state encoding and move direction encoding
//   - step_coord: the single boundary rule (clamp or wrap) used for both axes
// No ports (package).
// -----------------------------------------------------------------------------
package grid_pkg;

    localparam int GRID_COLS     = 8;
    localparam int GRID_ROWS     = 6;
    localparam int CELL_PIXELS   = 20;
    localparam int SQUARE_PIXELS = CELL_PIXELS * CELL_PIXELS;
    localparam int DONE_TIMEOUT  = 408;

    localparam int COORD_W = 4;
    localparam int CNT_W   = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ERASE_ARM = 3'd1,
        ST_ERASE     = 3'd2,
        ST_DRAW_ARM  = 3'd3,
        ST_DRAW      = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    // One step along an axis. The edge test happens before the add/subtract,
    // so a decrement at 0 never underflows and an increment never passes last.
    function automatic logic [COORD_W-1:0] step_coord(
        input logic [COORD_W-1:0] c,
        input logic               inc,
        input logic [COORD_W-1:0] last,
        input logic               wrap
    );
        logic [COORD_W-1:0] r;
        if (inc) begin
            if (c >= last) r = wrap ? '0 : last;
            else           r = COORD_W'(c + 1);
        end else begin
            if (c == '0)   r = wrap ? last : '0;
            else           r = COORD_W'(c - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/grid_cursor_next.sv
// -----------------------------------------------------------------------------
// grid_cursor_next
// Combinational next-cell computation for the grid cursor.
// Move priority is up > down > left > right; edges clamp by default.
// Build option: define GRID_CURSOR_WRAP_EN to make moves wrap around the grid
// instead of clamping.
// Ports:
//   cur_x, cur_y        in   current cursor cell
//   move_up/down/left/right in single-cycle move requests
//   nxt_x, nxt_y        out  resulting cell
//   changed             out  1 when the resulting cell differs from cur
// -----------------------------------------------------------------------------
module grid_cursor_next
    import grid_pkg::*;
(
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  logic               move_up,
    input  logic               move_down,
    input  logic               move_left,
    input  logic               move_right,
    output logic [COORD_W-1:0] nxt_x,
    output logic [COORD_W-1:0] nxt_y,
    output logic               changed
);

`ifdef GRID_CURSOR_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(GRID_COLS - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(GRID_ROWS - 1);

    dir_t dir;

    always_comb begin
        dir = DIR_NONE;
        if      (move_up)    dir = DIR_UP;
        else if (move_down)  dir = DIR_DOWN;
        else if (move_left)  dir = DIR_LEFT;
        else if (move_right) dir = DIR_RIGHT;
    end

    always_comb begin
        nxt_x = cur_x;
        nxt_y = cur_y;
        case (dir)
            DIR_UP:    nxt_y = step_coord(cur_y, 1'b0, LAST_Y, WRAP);
            DIR_DOWN:  nxt_y = step_coord(cur_y, 1'b1, LAST_Y, WRAP);
            DIR_LEFT:  nxt_x = step_coord(cur_x, 1'b0, LAST_X, WRAP);
            DIR_RIGHT: nxt_x = step_coord(cur_x, 1'b1, LAST_X, WRAP);
            default:   ;
        endcase
        changed = (nxt_x != cur_x) || (nxt_y != cur_y);
    end

endmodule

// File: rtl/grid_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// grid_cursor_ctrl
// Upstream controller for the 20x20 grid-selection square drawer. Holds the
// cursor cell and turns move/select pulses into an erase-old / draw-new
// square sequence. Build option GRID_CURSOR_WRAP_EN (see grid_cursor_next)
// makes moves wrap at the grid edges.
// Handshake: move_* and select are single-cycle pulses accepted only while
// busy=0; pulses seen while busy=1 are dropped. sel_valid and draw_err are
// single-cycle pulses; sel_x/sel_y are valid when sel_valid=1.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   move_up/down/left/right    move pulses
//   select                     select pulse (priority over moves)
//   square_done                drawer done flag
//   COUNTER_X, COUNTER_Y       cell handed to the drawer
//   drawer_resetn              0 = hold drawer at pixel 0, 1 = run
//   plot                       VGA write enable
//   erase                      1 = background colour, 0 = drawer colour
//   busy                       high in every state except IDLE
//   sel_valid, sel_x, sel_y    selected cell report
//   draw_err                   pulse on draw-phase timeout
// -----------------------------------------------------------------------------
module grid_cursor_ctrl
    import grid_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               move_up,
    input  logic               move_down,
    input  logic               move_left,
    input  logic               move_right,
    input  logic               select,
    input  logic               square_done,
    output logic [COORD_W-1:0] COUNTER_X,
    output logic [COORD_W-1:0] COUNTER_Y,
    output logic               drawer_resetn,
    output logic               plot,
    output logic               erase,
    output logic               busy,
    output logic               sel_valid,
    output logic [COORD_W-1:0] sel_x,
    output logic [COORD_W-1:0] sel_y,
    output logic               draw_err
);

    state_t             state;
    logic [COORD_W-1:0] cur_x, cur_y;
    logic [COORD_W-1:0] tgt_x, tgt_y;
    logic [COORD_W-1:0] nxt_x, nxt_y;
    logic               changed;
    logic [CNT_W-1:0]   pix_cnt;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               pix_full;
    logic               done_ok;
    logic               tmo_hit;

    grid_cursor_next u_next (
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .move_up    (move_up),
        .move_down  (move_down),
        .move_left  (move_left),
        .move_right (move_right),
        .nxt_x      (nxt_x),
        .nxt_y      (nxt_y),
        .changed    (changed)
    );

    assign pix_full = (pix_cnt == CNT_W'(SQUARE_PIXELS));
    // The drawer's done flag is stale for the first cycle after release.
    assign done_ok  = square_done && (pix_cnt >= CNT_W'(2)) && pix_full;
    assign tmo_hit  = (tmo_cnt == CNT_W'(DONE_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_DRAW_ARM;
            cur_x         <= '0;
            cur_y         <= '0;
            tgt_x         <= '0;
            tgt_y         <= '0;
            COUNTER_X     <= '0;
            COUNTER_Y     <= '0;
            drawer_resetn <= 1'b0;
            plot          <= 1'b0;
            erase         <= 1'b0;
            busy          <= 1'b1;
            sel_valid     <= 1'b0;
            sel_x         <= '0;
            sel_y         <= '0;
            draw_err      <= 1'b0;
            pix_cnt       <= '0;
            tmo_cnt       <= '0;
        end else begin
            sel_valid <= 1'b0;
            draw_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    drawer_resetn <= 1'b0;
                    plot          <= 1'b0;
                    busy          <= 1'b0;
                    if (select) begin
                        sel_valid <= 1'b1;
                        sel_x     <= cur_x;
                        sel_y     <= cur_y;
                    end else if (changed) begin
                        tgt_x     <= nxt_x;
                        tgt_y     <= nxt_y;
                        COUNTER_X <= cur_x;
                        COUNTER_Y <= cur_y;
                        erase     <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_ERASE_ARM;
                    end
                end

                // Arm cycle: drawer held at pixel 0 with coordinates already
                // stable; release it for the following phase.
                ST_ERASE_ARM, ST_DRAW_ARM: begin
                    drawer_resetn <= 1'b1;
                    plot          <= 1'b0;
                    pix_cnt       <= '0;
                    tmo_cnt       <= '0;
                    state         <= (state == ST_ERASE_ARM) ? ST_ERASE : ST_DRAW;
                end

                // plot trails drawer_resetn by one cycle to match the
                // drawer's colour/coordinate latency.
                ST_ERASE, ST_DRAW: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    plot    <= !pix_full;
                    if (!pix_full) pix_cnt <= pix_cnt + CNT_W'(1);
                    if (done_ok || tmo_hit) begin
                        draw_err      <= !done_ok;
                        plot          <= 1'b0;
                        drawer_resetn <= 1'b0;
                        if (state == ST_ERASE) begin
                            cur_x     <= tgt_x;
                            cur_y     <= tgt_y;
                            COUNTER_X <= tgt_x;
                            COUNTER_Y <= tgt_y;
                            erase     <= 1'b0;
                            state     <= ST_DRAW_ARM;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    drawer_resetn <= 1'b0;
                    plot          <= 1'b0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_grid_cursor_ctrl
// Directed bench for grid_cursor_ctrl with a simple drawer model that raises
// square_done after 400 released cycles (or never, when done_en=0).
// Honours GRID_CURSOR_WRAP_EN for the edge scenarios.
// -----------------------------------------------------------------------------
module tb_grid_cursor_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0;
    logic       select = 1'b0;
    logic       square_done;
    logic [3:0] COUNTER_X, COUNTER_Y;
    logic       drawer_resetn, plot, erase, busy, sel_valid, draw_err;
    logic [3:0] sel_x, sel_y;

    int vectors = 0;
    int miscompares = 0;
    int exp_x = 0;
    int exp_y = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- drawer model ----------------
    logic       done_en = 1'b1;
    logic [8:0] dcnt = 9'd0;
    always @(posedge clk) begin
        if (!drawer_resetn)   dcnt <= 9'd0;
        else if (dcnt != 9'd511) dcnt <= dcnt + 9'd1;
    end
    assign square_done = done_en && (dcnt >= 9'd400);

    grid_cursor_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .move_up       (move_up),
        .move_down     (move_down),
        .move_left     (move_left),
        .move_right    (move_right),
        .select        (select),
        .square_done   (square_done),
        .COUNTER_X     (COUNTER_X),
        .COUNTER_Y     (COUNTER_Y),
        .drawer_resetn (drawer_resetn),
        .plot          (plot),
        .erase         (erase),
        .busy          (busy),
        .sel_valid     (sel_valid),
        .sel_x         (sel_x),
        .sel_y         (sel_y),
        .draw_err      (draw_err)
    );

    // ---------------- driver tasks ----------------
    // pv = {select, up, down, left, right}; held for one cycle, returns at
    // the negedge right after the sampling posedge.
    task automatic pulse(input logic [4:0] pv);
        @(negedge clk);
        {select, move_up, move_down, move_left, move_right} = pv;
        @(negedge clk);
        {select, move_up, move_down, move_left, move_right} = 5'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int k = 0;
        while (busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        ok = !busy;
    endtask

    // Counts activity with no busy/plot/drawer release over n cycles.
    task automatic watch_quiet(input int n, output int nact);
        nact = 0;
        for (int i = 0; i < n; i++) begin
            if (busy || plot || drawer_resetn) nact++;
            @(negedge clk);
        end
    endtask

    // Follows one erase or draw phase from its arm cycle to the exit sample.
    // first_lat: cycles from the pulse edge to the first plot (call right
    // after pulse()).
    task automatic observe(input logic exp_erase, input logic [3:0] ex, input logic [3:0] ey,
                           output int ncyc, output int nplot, output int nbad,
                           output int nerr, output int first_lat);
        int k = 1;
        ncyc = 0; nplot = 0; nbad = 0; nerr = 0; first_lat = -1;
        while (!drawer_resetn && k < 12) begin
            @(negedge clk);
            k++;
        end
        while (drawer_resetn && ncyc < 600) begin
            if (plot) begin
                if (first_lat < 0) first_lat = k;
                nplot++;
                if (erase !== exp_erase || COUNTER_X !== ex || COUNTER_Y !== ey) nbad++;
            end
            if (draw_err) nerr++;
            ncyc++;
            @(negedge clk);
            k++;
        end
        if (draw_err) nerr++;
    endtask

    task automatic do_select(output logic v, output logic [3:0] sx, output logic [3:0] sy);
        pulse(5'b10000);
        v = sel_valid; sx = sel_x; sy = sel_y;
    endtask

    // Straight moves that never hit an edge, tracking exp_x/exp_y.
    task automatic goto(input int tx, input int ty, output int nto);
        bit ok;
        nto = 0;
        while (exp_x < tx) begin pulse(5'b00001); wait_idle(ok); if (!ok) nto++; exp_x++; end
        while (exp_x > tx) begin pulse(5'b00010); wait_idle(ok); if (!ok) nto++; exp_x--; end
        while (exp_y < ty) begin pulse(5'b00100); wait_idle(ok); if (!ok) nto++; exp_y++; end
        while (exp_y > ty) begin pulse(5'b01000); wait_idle(ok); if (!ok) nto++; exp_y--; end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset;
        int ncyc, nplot, nbad, nerr, lat;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({drawer_resetn, plot, erase, busy, sel_valid, draw_err} !== 6'b000100) begin
            miscompares++;
            $display("FAIL reset_ctrl: got resetn/plot/erase/busy/selv/err=%b expected 000100",
                     {drawer_resetn, plot, erase, busy, sel_valid, draw_err});
        end
        vectors++;
        if ({COUNTER_X, COUNTER_Y, sel_x, sel_y} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_coords: got cnt=(%0d,%0d) sel=(%0d,%0d) expected all 0",
                     COUNTER_X, COUNTER_Y, sel_x, sel_y);
        end
        reset = 1'b0;
        observe(1'b0, 4'd0, 4'd0, ncyc, nplot, nbad, nerr, lat);
        vectors++;
        if (nplot !== 400) begin miscompares++; $display("FAIL reset_draw_plots: got %0d expected 400", nplot); end
        vectors++;
        if (nbad !== 0 || nerr !== 0) begin
            miscompares++; $display("FAIL reset_draw_attr: got bad=%0d err=%0d expected 0/0", nbad, nerr);
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_clamp_origin;
        int nact;
        pulse(5'b01000);
        watch_quiet(6, nact);
        vectors++;
        if (nact !== 0) begin miscompares++; $display("FAIL clamp_up_origin: got %0d active cycles expected 0", nact); end
        pulse(5'b00010);
        watch_quiet(6, nact);
        vectors++;
        if (nact !== 0) begin miscompares++; $display("FAIL clamp_left_origin: got %0d active cycles expected 0", nact); end
    endtask

    task automatic test_move_right;
        int ncyc, nplot, nbad, nerr, lat;
        logic v; logic [3:0] sx, sy;
        pulse(5'b00001);
        vectors++;
        if ({busy, erase, drawer_resetn, COUNTER_X, COUNTER_Y} !== {3'b110, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL move_erase_arm: got busy/erase/resetn=%b cnt=(%0d,%0d) expected 110 (0,0)",
                     {busy, erase, drawer_resetn}, COUNTER_X, COUNTER_Y);
        end
        observe(1'b1, 4'd0, 4'd0, ncyc, nplot, nbad, nerr, lat);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL move_first_plot_latency: got %0d expected 3", lat); end
        vectors++;
        if (nplot !== 400 || nbad !== 0 || ncyc !== 401) begin
            miscompares++;
            $display("FAIL move_erase_phase: got plots=%0d bad=%0d cyc=%0d expected 400/0/401", nplot, nbad, ncyc);
        end
        observe(1'b0, 4'd1, 4'd0, ncyc, nplot, nbad, nerr, lat);
        vectors++;
        if (nplot !== 400 || nbad !== 0 || nerr !== 0) begin
            miscompares++;
            $display("FAIL move_draw_phase: got plots=%0d bad=%0d err=%0d expected 400/0/0", nplot, nbad, nerr);
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL move_done_busy: got %b expected 0", busy); end
        exp_x = 1;
        do_select(v, sx, sy);
        vectors++;
        if ({v, sx, sy} !== {1'b1, 4'd1, 4'd0}) begin
            miscompares++; $display("FAIL move_sel: got v=%b (%0d,%0d) expected 1 (1,0)", v, sx, sy);
        end
    endtask

    task automatic test_walk_corner;
        int nto;
        logic v; logic [3:0] sx, sy;
        goto(7, 5, nto);
        vectors++;
        if (nto !== 0) begin miscompares++; $display("FAIL walk_timeouts: got %0d expected 0", nto); end
        do_select(v, sx, sy);
        vectors++;
        if ({v, sx, sy} !== {1'b1, 4'd7, 4'd5}) begin
            miscompares++; $display("FAIL walk_sel: got v=%b (%0d,%0d) expected 1 (7,5)", v, sx, sy);
        end
    endtask

    task automatic test_edge;
        logic v; logic [3:0] sx, sy;
`ifdef GRID_CURSOR_WRAP_EN
        int ncyc, nplot, nbad, nerr, lat;
        pulse(5'b00001);
        observe(1'b1, 4'd7, 4'd5, ncyc, nplot, nbad, nerr, lat);
        observe(1'b0, 4'd0, 4'd5, ncyc, nplot, nbad, nerr, lat);
        vectors++;
        if (nplot !== 400 || nbad !== 0) begin
            miscompares++; $display("FAIL wrap_right_draw: got plots=%0d bad=%0d expected 400/0", nplot, nbad);
        end
        pulse(5'b00100);
        observe(1'b1, 4'd0, 4'd5, ncyc, nplot, nbad, nerr, lat);
        observe(1'b0, 4'd0, 4'd0, ncyc, nplot, nbad, nerr, lat);
        vectors++;
        if (nplot !== 400 || nbad !== 0) begin
            miscompares++; $display("FAIL wrap_down_draw: got plots=%0d bad=%0d expected 400/0", nplot, nbad);
        end
        exp_x = 0; exp_y = 0;
`else
        int nact;
        pulse(5'b00001);
        watch_quiet(6, nact);
        vectors++;
        if (nact !== 0) begin miscompares++; $display("FAIL clamp_right_edge: got %0d active cycles expected 0", nact); end
        pulse(5'b00100);
        watch_quiet(6, nact);
        vectors++;
        if (nact !== 0) begin miscompares++; $display("FAIL clamp_down_edge: got %0d active cycles expected 0", nact); end
`endif
        do_select(v, sx, sy);
        vectors++;
        if ({v, sx, sy} !== {1'b1, exp_x[3:0], exp_y[3:0]}) begin
            miscompares++;
            $display("FAIL edge_sel: got v=%b (%0d,%0d) expected 1 (%0d,%0d)", v, sx, sy, exp_x, exp_y);
        end
    endtask

    task automatic test_select_priority;
        int nto, nact;
        logic v; logic [3:0] sx, sy;
        goto(3, 2, nto);
        vectors++;
        if (nto !== 0) begin miscompares++; $display("FAIL goto_3_2_timeouts: got %0d expected 0", nto); end
        pulse(5'b11000);
        vectors++;
        if ({sel_valid, sel_x, sel_y, busy} !== {1'b1, 4'd3, 4'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL sel_over_move: got v=%b (%0d,%0d) busy=%b expected 1 (3,2) 0", sel_valid, sel_x, sel_y, busy);
        end
        watch_quiet(6, nact);
        vectors++;
        if (nact !== 0 || sel_valid !== 1'b0) begin
            miscompares++; $display("FAIL sel_no_move: got active=%0d selv=%b expected 0/0", nact, sel_valid);
        end
        do_select(v, sx, sy);
        vectors++;
        if ({v, sx, sy} !== {1'b1, 4'd3, 4'd2}) begin
            miscompares++; $display("FAIL sel_repeat: got v=%b (%0d,%0d) expected 1 (3,2)", v, sx, sy);
        end
    endtask

    task automatic test_busy_drop;
        int ncyc, nplot, nbad, nerr, lat, nact, k;
        bit ok;
        logic v; logic [3:0] sx, sy;
        pulse(5'b00100);
        observe(1'b1, 4'd3, 4'd2, ncyc, nplot, nbad, nerr, lat);
        vectors++;
        if (nplot !== 400 || nbad !== 0) begin
            miscompares++; $display("FAIL drop_erase_phase: got plots=%0d bad=%0d expected 400/0", nplot, nbad);
        end
        k = 0;
        while (!drawer_resetn && k < 12) begin @(negedge clk); k++; end
        repeat (50) @(negedge clk);
        pulse(5'b00010);
        wait_idle(ok);
        watch_quiet(6, nact);
        vectors++;
        if (!ok || nact !== 0) begin
            miscompares++; $display("FAIL drop_left_ignored: got idle=%0d active=%0d expected 1/0", ok, nact);
        end
        exp_y = 3;
        do_select(v, sx, sy);
        vectors++;
        if ({v, sx, sy} !== {1'b1, 4'd3, 4'd3}) begin
            miscompares++; $display("FAIL drop_sel: got v=%b (%0d,%0d) expected 1 (3,3)", v, sx, sy);
        end
    endtask

    task automatic test_timeout;
        int ncyc, nplot, nbad, nerr, lat;
        logic v; logic [3:0] sx, sy;
        done_en = 1'b0;
        pulse(5'b00001);
        observe(1'b1, 4'd3, 4'd3, ncyc, nplot, nbad, nerr, lat);
        vectors++;
        if (ncyc !== 408 || nerr !== 1 || nplot !== 400) begin
            miscompares++;
            $display("FAIL tmo_erase: got cyc=%0d err=%0d plots=%0d expected 408/1/400", ncyc, nerr, nplot);
        end
        observe(1'b0, 4'd4, 4'd3, ncyc, nplot, nbad, nerr, lat);
        vectors++;
        if (ncyc !== 408 || nerr !== 1 || nbad !== 0) begin
            miscompares++;
            $display("FAIL tmo_draw: got cyc=%0d err=%0d bad=%0d expected 408/1/0", ncyc, nerr, nbad);
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL tmo_idle_busy: got %b expected 0", busy); end
        @(negedge clk);
        vectors++;
        if (draw_err !== 1'b0) begin miscompares++; $display("FAIL tmo_err_pulse_width: got %b expected 0", draw_err); end
        done_en = 1'b1;
        exp_x = 4;
        do_select(v, sx, sy);
        vectors++;
        if ({v, sx, sy} !== {1'b1, 4'd4, 4'd3}) begin
            miscompares++; $display("FAIL tmo_sel: got v=%b (%0d,%0d) expected 1 (4,3)", v, sx, sy);
        end
    endtask

    task automatic test_mid_reset;
        int ncyc, nplot, nbad, nerr, lat, k, np;
        logic v; logic [3:0] sx, sy;
        pulse(5'b01000);
        k = 0;
        while (!drawer_resetn && k < 12) begin @(negedge clk); k++; end
        np = 0; k = 0;
        while (np < 150 && k < 600) begin
            if (plot) np++;
            if (np < 150) @(negedge clk);
            k++;
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({drawer_resetn, plot, erase, busy, sel_valid, draw_err} !== 6'b000100 ||
            {COUNTER_X, COUNTER_Y} !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_values: got ctrl=%b cnt=(%0d,%0d) expected 000100 (0,0)",
                     {drawer_resetn, plot, erase, busy, sel_valid, draw_err}, COUNTER_X, COUNTER_Y);
        end
        reset = 1'b0;
        observe(1'b0, 4'd0, 4'd0, ncyc, nplot, nbad, nerr, lat);
        vectors++;
        if (nplot !== 400 || nbad !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_redraw: got plots=%0d bad=%0d busy=%b expected 400/0/0", nplot, nbad, busy);
        end
        exp_x = 0; exp_y = 0;
        do_select(v, sx, sy);
        vectors++;
        if ({v, sx, sy} !== {1'b1, 4'd0, 4'd0}) begin
            miscompares++; $display("FAIL midreset_sel: got v=%b (%0d,%0d) expected 1 (0,0)", v, sx, sy);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
`ifndef GRID_CURSOR_WRAP_EN
        test_clamp_origin();
`endif
        test_move_right();
        test_walk_corner();
        test_edge();
        test_select_priority();
        test_busy_drop();
        test_timeout();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/grid_cursor_ctrl.md
Name: grid_cursor_ctrl

Overview:
- Upstream controller for the 20x20 grid-selection square drawer.
- Holds the cursor's grid cell and turns single-cycle move/select pulses into an erase-old-square / draw-new-square sequence.
- Drives the drawer's grid coordinates and its active-low run/hold reset, and gates VGA plot writes.
- Reports the selected cell to the game logic.

Parameters:
- GRID_COLS, 8, number of grid columns (160 px / 20).
- GRID_ROWS, 6, number of grid rows (120 px / 20).
- SQUARE_PIXELS, 400, pixels emitted per square.
- DONE_TIMEOUT, 408, cycles in a draw phase before forced abort.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- move_up / move_down / move_left / move_right  in  1 each  single-cycle move pulses
- select  in  1  single-cycle select pulse
- square_done  in  1  drawer done flag
- COUNTER_X  out  4  cursor column to drawer
- COUNTER_Y  out  4  cursor row to drawer
- drawer_resetn  out  1  0 = hold drawer at pixel 0, 1 = run
- plot  out  1  VGA write enable
- erase  out  1  1 = colour mux selects background, 0 = drawer colour
- busy  out  1  high in every state except IDLE
- sel_valid  out  1  one-cycle pulse on accepted select
- sel_x  out  4  registered column, valid with sel_valid
- sel_y  out  4  registered row, valid with sel_valid
- draw_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset values: cur_x=cur_y=0, COUNTER_X=COUNTER_Y=0, state=DRAW_ARM (paints initial cursor). drawer_resetn=0, plot=0, erase=0, sel_valid=0, sel_x=sel_y=0, draw_err=0, busy=1.
- Reset asserted mid-sequence aborts immediately to the reset values above.
- States: IDLE, ERASE_ARM, ERASE, DRAW_ARM, DRAW.
- IDLE: drawer_resetn=0, plot=0, busy=0.
  - select has priority over moves. On select: sel_valid=1 next cycle, sel_x/sel_y=cur; state stays IDLE.
  - Else on a move: priority up>down>left>right; compute nxt.
  - up: y-1; down: y+1; left: x-1; right: x+1. Clamp at 0 and GRID_COLS-1 / GRID_ROWS-1.
  - nxt==cur (edge clamp): no-op, stay IDLE.
  - Otherwise latch nxt and go to ERASE_ARM.
- Pulses arriving while busy=1 are dropped, not queued.
- ERASE_ARM (1 cycle): COUNTER=cur, erase=1, drawer_resetn=0; then ERASE.
- ERASE: drawer_resetn=1, erase=1, COUNTER=cur.
  - 9-bit pix_cnt starts at 0.
  - plot=1 for exactly SQUARE_PIXELS consecutive cycles, beginning the cycle after drawer_resetn rises (drawer colour and x/y have 1-cycle latency).
  - square_done is ignored until pix_cnt>=2, because the drawer clears its stale done flag one cycle after release.
  - Exit when pix_cnt==SQUARE_PIXELS and square_done==1: cur<=nxt, go to DRAW_ARM.
- DRAW_ARM / DRAW: identical to ERASE_ARM / ERASE with erase=0. Exit to IDLE.
- Timeout: if a phase's cycle count reaches DONE_TIMEOUT without exit, pulse draw_err for 1 cycle.
  - Timeout in ERASE: proceeds as a normal exit.
  - Timeout in DRAW: goes to IDLE.
- Widths: pix_cnt and the timeout counter are 9 bits; coordinates are 4 bits with unsigned compare. Decrement at 0 never underflows (clamp is checked before subtract).
- Latency: the first plot of a move occurs 3 cycles after the move pulse. A move completes in about 2×(SQUARE_PIXELS+3) cycles.

Optional Feature:
- Macro: GRID_CURSOR_WRAP_EN.
- Defined: moves wrap instead of clamping.
  - left at x=0 goes to GRID_COLS-1; right at GRID_COLS-1 goes to 0; same for rows.
  - A wrap is never a no-op (requires GRID_COLS, GRID_ROWS ≥ 2).
- Undefined: clamp as above.

Decomposition:
- Shared package grid_pkg: GRID_COLS, GRID_ROWS, CELL_PIXELS=20, SQUARE_PIXELS, state encoding, direction encoding.
- One sub-module, grid_cursor_next: combinational next-cell computation (priority, clamp/wrap) with a reusable boundary rule. FSM and counters stay in the top.

Test Plan:
- Post-reset: release reset with drawer model → exactly 400 plot cycles with erase=0 at COUNTER=(0,0), busy falls, then IDLE.
- Move right from (0,0): pulse move_right → 400 plot cycles erase=1 at (0,0), then 400 plot cycles erase=0 at (1,0); cur=(1,0).
- Edge clamp: at (7,5), pulse move_right then move_down → no plot, busy stays 0. With GRID_CURSOR_WRAP_EN: move_right reaches (0,5).
- Simultaneous / busy drop: select+move_up at (3,2) → sel_valid with sel=(3,2), no move. move_left during DRAW → ignored, final cur unchanged.
- Timeout: drawer model never raises square_done → draw_err pulse at cycle 408 of ERASE, and again in DRAW, which returns to IDLE.
- Mid-operation reset: assert reset at plot cycle 150 of ERASE → next cycle all outputs at reset values, state DRAW_ARM, cur=(0,0).
